// File: rtl/serial_adder.sv
// serial_adder
//   Bit-serial WIDTH-bit adder computing a + b + cin, one bit per clock, LSB
//   first. Operands are captured on an accepted start. A full adder is built
//   from two half adders and a carry flop. After WIDTH RUN cycles, a
//   one-cycle done pulse marks sum/cout/ovf as valid. The results then hold
//   through IDLE until the next accepted start.
//
// Ports
//   clk    in   rising-edge clock
//   rst    in   asynchronous active-high reset
//   start  in   begin an addition (only honoured in IDLE)
//   a, b   in   WIDTH-bit operands, captured on the accepting edge
//   cin    in   carry-in, captured on the accepting edge
//   busy   out  high while in RUN
//   done   out  one-cycle pulse, results valid
//   sum    out  a+b+cin modulo 2^WIDTH
//   cout   out  unsigned carry out of the MSB
//   ovf    out  signed two's complement overflow
//
// state | meaning
// IDLE  | waiting for start, previous result held
// RUN   | one bit processed per clock, sum shifting
// DONE  | result valid for exactly one cycle

module serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic             carry;
    logic [CNT_W-1:0] cnt;

    // Full adder from two half adders
    logic ha0_s, ha0_c;
    logic ha1_s, ha1_c;
    logic bit_s, carry_nxt;

    always_comb begin
        ha0_s     = a_sh[0] ^ b_sh[0];
        ha0_c     = a_sh[0] & b_sh[0];
        ha1_s     = ha0_s ^ carry;
        ha1_c     = ha0_s & carry;
        bit_s     = ha1_s;
        carry_nxt = ha0_c | ha1_c;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            a_sh  <= '0;
            b_sh  <= '0;
            carry <= 1'b0;
            cnt   <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
            sum   <= '0;
            cout  <= 1'b0;
            ovf   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        a_sh  <= a;
                        b_sh  <= b;
                        carry <= cin;
                        cnt   <= '0;
                        busy  <= 1'b1;
                        state <= RUN;
                    end
                end

                RUN: begin
                    sum   <= {bit_s, sum[WIDTH-1:1]};
                    a_sh  <= {1'b0, a_sh[WIDTH-1:1]};
                    b_sh  <= {1'b0, b_sh[WIDTH-1:1]};
                    carry <= carry_nxt;
                    if (cnt == CNT_LAST) begin
                        // carry here is the carry into the MSB; carry_nxt is
                        // the carry out, so their XOR is signed overflow.
                        cout  <= carry_nxt;
                        ovf   <= carry ^ carry_nxt;
                        cnt   <= '0;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= DONE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end

                DONE: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end

                default: begin
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_adder.sv
module tb_serial_adder;

    localparam int WIDTH = 8;

    logic             clk;
    logic             rst;
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;

    int n_chk;
    int n_fail;

    serial_adder #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .b     (b),
        .cin   (cin),
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .cout  (cout),
        .ovf   (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Launch one addition and wait for done; checks latency, busy length,
    // results and that done drops after one cycle.
    task automatic run_op(input logic [7:0] va, input logic [7:0] vb, input logic vc,
                          input logic [7:0] e_sum, input logic e_cout, input logic e_ovf,
                          input string tag);
        int cycles;
        int busy_cnt;
        @(negedge clk);
        start = 1'b1; a = va; b = vb; cin = vc;
        @(negedge clk);
        start = 1'b0; a = ~va; b = ~vb; cin = ~vc;
        cycles = 0;
        busy_cnt = 0;
        while (!done && cycles < 40) begin
            if (busy) busy_cnt++;
            @(negedge clk);
            cycles++;
        end
        chk({tag, " done_seen"}, 32'(done), 32'd1);
        chk({tag, " latency"}, 32'(cycles), 32'(WIDTH));
        chk({tag, " busy_len"}, 32'(busy_cnt), 32'(WIDTH));
        chk({tag, " sum"}, 32'(sum), 32'(e_sum));
        chk({tag, " cout"}, 32'(cout), 32'(e_cout));
        chk({tag, " ovf"}, 32'(ovf), 32'(e_ovf));
        @(negedge clk);
        chk({tag, " done_pulse"}, 32'(done), 32'd0);
    endtask

    initial begin
        int cyc;
        int dones;
        int last_t;
        int t;
        logic [8:0] full;
        logic [7:0] ra, rb;
        logic       rc, eo;

        n_chk = 0;
        n_fail = 0;
        rst = 1'b1; start = 1'b0; a = '0; b = '0; cin = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst busy", 32'(busy), 32'd0);
        chk("rst done", 32'(done), 32'd0);
        chk("rst sum", 32'(sum), 32'd0);
        chk("rst cout", 32'(cout), 32'd0);
        chk("rst ovf", 32'(ovf), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        run_op(8'h35, 8'h4A, 1'b0, 8'h7F, 1'b0, 1'b0, "v35_4a");
        run_op(8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0, "vff_01");
        run_op(8'hFF, 8'h00, 1'b1, 8'h00, 1'b1, 1'b0, "vff_00_c");
        run_op(8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1, "v7f_01");
        run_op(8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1, "v80_80");

        // start pulsed during RUN must be ignored
        @(negedge clk);
        start = 1'b1; a = 8'h10; b = 8'h20; cin = 1'b0;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        start = 1'b1; a = 8'hAA; b = 8'h55; cin = 1'b1;
        @(negedge clk);
        start = 1'b0;
        dones = 0;
        for (int i = 0; i < 30; i++) begin
            if (done) dones++;
            @(negedge clk);
        end
        chk("ign done_count", 32'(dones), 32'd1);
        chk("ign sum", 32'(sum), 32'h30);
        chk("ign cout", 32'(cout), 32'd0);
        chk("ign hold_busy", 32'(busy), 32'd0);

        // reset three cycles into RUN
        @(negedge clk);
        start = 1'b1; a = 8'hFF; b = 8'h01; cin = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        chk("abort busy_before", 32'(busy), 32'd1);
        rst = 1'b1;
        #1;
        chk("abort busy", 32'(busy), 32'd0);
        chk("abort done", 32'(done), 32'd0);
        chk("abort sum", 32'(sum), 32'd0);
        chk("abort cout", 32'(cout), 32'd0);
        chk("abort ovf", 32'(ovf), 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        dones = 0;
        for (int i = 0; i < 15; i++) begin
            if (done || busy) dones++;
            @(negedge clk);
        end
        chk("abort no_activity", 32'(dones), 32'd0);
        run_op(8'h01, 8'h01, 1'b0, 8'h02, 1'b0, 1'b0, "post_rst");

        // start held: one result every WIDTH+2 cycles
        @(negedge clk);
        start = 1'b1; a = 8'h03; b = 8'h04; cin = 1'b0;
        dones = 0;
        last_t = -1;
        for (cyc = 0; cyc < 45; cyc++) begin
            @(negedge clk);
            if (done) begin
                chk("b2b sum", 32'(sum), 32'h07);
                if (last_t >= 0) begin
                    t = cyc - last_t;
                    chk("b2b period", 32'(t), 32'(WIDTH + 2));
                end
                last_t = cyc;
                dones++;
            end
        end
        start = 1'b0;
        chk("b2b count", 32'(dones >= 4), 32'd1);
        repeat (12) @(negedge clk);

        // random regression
        for (int i = 0; i < 1000; i++) begin
            ra = 8'($urandom_range(0, 255));
            rb = 8'($urandom_range(0, 255));
            rc = 1'($urandom_range(0, 1));
            full = {1'b0, ra} + {1'b0, rb} + {8'd0, rc};
            eo = (ra[7] == rb[7]) && (full[7] != ra[7]);
            @(negedge clk);
            start = 1'b1; a = ra; b = rb; cin = rc;
            @(negedge clk);
            start = 1'b0; a = $urandom; b = $urandom;
            cyc = 0;
            while (!done && cyc < 40) begin
                @(negedge clk);
                cyc++;
            end
            chk("rnd done", 32'(done), 32'd1);
            chk("rnd sum", 32'(sum), 32'(full[7:0]));
            chk("rnd cout", 32'(cout), 32'(full[8]));
            chk("rnd ovf", 32'(ovf), 32'(eo));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
